// File: rtl/bound_pkg.sv
// bound_pkg: shared widths, FSM states and the saturating requantizer
package bound_pkg;
  localparam int AB_BW = 21;
  localparam int D_BW = 8;
  localparam int SAT_MAX = 2 ** (D_BW - 1) - 1;
  localparam int SAT_MIN = -(2 ** (D_BW - 1));
  typedef enum logic {IDLE, LOCKED} state_t;
  typedef struct packed {
    logic [D_BW-1:0] data;
    logic sat;
  } sat_t;
  function automatic sat_t saturate(input logic signed [AB_BW-1:0] x);
    sat_t r;
    r.data = x > SAT_MAX ? D_BW'(SAT_MAX) : x < SAT_MIN ? D_BW'(SAT_MIN) : x[D_BW-1:0];
    r.sat = x > SAT_MAX || x < SAT_MIN;
    return r;
  endfunction
endpackage

// File: rtl/bound_arbiter_if.sv
// bound_arbiter_if: lane request bus plus tagged output stream
interface bound_arbiter_if #(parameter int NUM_REQ = 4, parameter int ID_BW = 2);
  import bound_pkg::*;
  logic [NUM_REQ-1:0] i_req_valid;
  logic [NUM_REQ-1:0] o_req_ready;
  logic [NUM_REQ*AB_BW-1:0] i_req_data;
  logic [NUM_REQ-1:0] i_req_last;
  logic o_valid;
  logic i_ready;
  logic signed [D_BW-1:0] o_data;
  logic [ID_BW-1:0] o_id;
  logic o_last;
  logic o_sat;
  modport master (output i_req_valid, i_req_data, i_req_last, i_ready,
                  input o_req_ready, o_valid, o_data, o_id, o_last, o_sat);
  modport slave (input i_req_valid, i_req_data, i_req_last, i_ready,
                 output o_req_ready, o_valid, o_data, o_id, o_last, o_sat);
endinterface

// File: rtl/bound_rr_arb.sv
// bound_rr_arb: round-robin search for the first valid lane at or after ptr
module bound_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_BW = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_BW-1:0]   ptr,
  output logic [ID_BW-1:0]   gnt_id,
  output logic               gnt_vld
);
  logic [ID_BW-1:0] idx;
  // scan from the farthest offset down so the closest valid lane to ptr wins
  always_comb begin
    gnt_id = '0;
    gnt_vld = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_BW'((int'(ptr) + k) % NUM_REQ);
      if (valid[idx]) begin
        gnt_id = idx;
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bound_arbiter.sv
// bound_arbiter: round-robin, packet-locked sharing of one saturating requantizer
module bound_arbiter
  import bound_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_BW = 2,
  parameter int CNT_BW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr_cnt,
  bound_arbiter_if.slave    bus,
  output logic [CNT_BW-1:0] o_sat_cnt
);
  state_t state, state_nxt;
  logic [ID_BW-1:0] ptr, ptr_nxt, lock_id, lock_nxt, arb_id, sel;
  logic arb_vld, sel_vld, can_acc, acc;
  sat_t sat_r;
  bound_rr_arb #(.NUM_REQ(NUM_REQ), .ID_BW(ID_BW)) u_arb (
    .valid(bus.i_req_valid), .ptr(ptr), .gnt_id(arb_id), .gnt_vld(arb_vld)
  );
  assign can_acc = ~bus.o_valid | bus.i_ready;
  // pick the lane (locked owner or arbiter winner), accept it and plan next lock/pointer
  always_comb begin
    sel = state == LOCKED ? lock_id : arb_id;
    sel_vld = state == LOCKED ? bus.i_req_valid[sel] : arb_vld;
    acc = sel_vld & can_acc;
    bus.o_req_ready = acc ? NUM_REQ'(1) << sel : '0;
    state_nxt = acc ? (bus.i_req_last[sel] ? IDLE : LOCKED) : state;
    lock_nxt = acc ? sel : lock_id;
    ptr_nxt = acc & bus.i_req_last[sel] ? (int'(sel) == NUM_REQ - 1 ? '0 : sel + 1'b1) : ptr;
    sat_r = saturate(bus.i_req_data[sel*AB_BW +: AB_BW]);
  end
  // arbitration state: FSM, lock owner and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      lock_id <= '0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      lock_id <= lock_nxt;
    end
  end
  // registered output beat, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_valid <= 1'b0;
      bus.o_data <= '0;
      bus.o_id <= '0;
      bus.o_last <= 1'b0;
      bus.o_sat <= 1'b0;
    end else if (acc) begin
      bus.o_valid <= 1'b1;
      bus.o_data <= sat_r.data;
      bus.o_id <= sel;
      bus.o_last <= bus.i_req_last[sel];
      bus.o_sat <= sat_r.sat;
    end else if (bus.i_ready) begin
      bus.o_valid <= 1'b0;
    end
  end
  // saturation counter: clear wins, sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst || i_clr_cnt) o_sat_cnt <= '0;
    else if (bus.o_valid && bus.i_ready && bus.o_sat && o_sat_cnt != '1) o_sat_cnt <= o_sat_cnt + 1'b1;
  end
endmodule

// File: tb/tb_bound_arbiter.sv
// tb_bound_arbiter: directed self-checking bench for bound_arbiter
module tb_bound_arbiter;
  import bound_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [15:0] cnt;
  int total = 0;
  int bad = 0;
  bound_arbiter_if bif ();
  bound_arbiter dut (.clk(clk), .rst(rst), .i_clr_cnt(clr), .bus(bif.slave), .o_sat_cnt(cnt));
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input int k, input bit v, input int d, input bit l);
    bif.i_req_valid[k] = v;
    bif.i_req_data[k*AB_BW +: AB_BW] = AB_BW'(d);
    bif.i_req_last[k] = l;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bif.i_req_valid = '0;
    bif.i_req_data = '0;
    bif.i_req_last = '0;
    bif.i_ready = 1'b1;
    step;
    step;
    total++; if (bif.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bif.o_valid); end
    total++; if (bif.o_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h exp=0", bif.o_data); end
    total++; if (bif.o_id !== 2'd0 || bif.o_last !== 1'b0 || bif.o_sat !== 1'b0) begin bad++; $display("FAIL reset_tag got=%0d/%0b/%0b exp=0/0/0", bif.o_id, bif.o_last, bif.o_sat); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    total++; if (bif.o_req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", bif.o_req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single_lane;
    int vals[3] = '{16, 60, -128};
    for (int i = 0; i < 3; i++) begin
      lane(0, 1'b1, vals[i], 1'b1);
      #1;
      total++; if (bif.o_req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b exp=0001", bif.o_req_ready); end
      step;
      total++; if (bif.o_valid !== 1'b1 || bif.o_data !== 8'(vals[i])) begin bad++; $display("FAIL single_data got=%0b/%0h exp=1/%0h", bif.o_valid, bif.o_data, 8'(vals[i])); end
      total++; if (bif.o_sat !== 1'b0 || bif.o_id !== 2'd0 || bif.o_last !== 1'b1) begin bad++; $display("FAIL single_tag got=%0b/%0d/%0b exp=0/0/1", bif.o_sat, bif.o_id, bif.o_last); end
    end
    lane(0, 1'b0, 0, 1'b0);
    step;
    total++; if (bif.o_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%0b exp=0", bif.o_valid); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL single_cnt got=%0d exp=0", cnt); end
  endtask

  task automatic test_saturate;
    int ln[4] = '{1, 2, 2, 3};
    int d[4] = '{-1000, 200, 127, -129};
    logic [7:0] ed[4] = '{8'h80, 8'h7f, 8'h7f, 8'h80};
    logic es[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) lane(ln[i-1], 1'b0, 0, 1'b0);
      lane(ln[i], 1'b1, d[i], 1'b1);
      #1;
      total++; if (bif.o_req_ready !== 4'(1 << ln[i])) begin bad++; $display("FAIL sat_ready[%0d] got=%b exp=%b", i, bif.o_req_ready, 4'(1 << ln[i])); end
      step;
      total++; if (bif.o_data !== ed[i] || bif.o_sat !== es[i] || bif.o_id !== 2'(ln[i])) begin bad++; $display("FAIL sat_beat[%0d] got=%0h/%0b/%0d exp=%0h/%0b/%0d", i, bif.o_data, bif.o_sat, bif.o_id, ed[i], es[i], ln[i]); end
    end
    total++; if (cnt !== 16'd2) begin bad++; $display("FAIL sat_cnt_mid got=%0d exp=2", cnt); end
    lane(3, 1'b0, 0, 1'b0);
    step;
    total++; if (cnt !== 16'd3) begin bad++; $display("FAIL sat_cnt_end got=%0d exp=3", cnt); end
  endtask

  task automatic test_round_robin;
    for (int k = 0; k < 4; k++) lane(k, 1'b1, 10 + k, 1'b1);
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (bif.o_req_ready !== 4'(1 << (i % 4))) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, bif.o_req_ready, 4'(1 << (i % 4))); end
      step;
      total++; if (bif.o_valid !== 1'b1 || bif.o_id !== 2'(i % 4) || bif.o_data !== 8'(10 + i % 4)) begin bad++; $display("FAIL rr_beat[%0d] got=%0b/%0d/%0d exp=1/%0d/%0d", i, bif.o_valid, bif.o_id, bif.o_data, i % 4, 10 + i % 4); end
    end
    for (int k = 0; k < 4; k++) lane(k, 1'b0, 0, 1'b0);
    step;
  endtask

  task automatic test_lock;
    logic v0[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int d0[6] = '{1, 0, 0, 2, 3, 0};
    logic l0[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] er[6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010};
    logic ev[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] ei[6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    logic [7:0] ed[6] = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5};
    lane(1, 1'b1, 5, 1'b1);
    for (int i = 0; i < 6; i++) begin
      lane(0, v0[i], d0[i], l0[i]);
      #1;
      total++; if (bif.o_req_ready !== er[i]) begin bad++; $display("FAIL lock_ready[%0d] got=%b exp=%b", i, bif.o_req_ready, er[i]); end
      step;
      total++; if (bif.o_valid !== ev[i] || (ev[i] && (bif.o_id !== ei[i] || bif.o_data !== ed[i]))) begin bad++; $display("FAIL lock_beat[%0d] got=%0b/%0d/%0d exp=%0b/%0d/%0d", i, bif.o_valid, bif.o_id, bif.o_data, ev[i], ei[i], ed[i]); end
    end
    lane(1, 1'b0, 0, 1'b0);
    step;
  endtask

  task automatic test_backpressure;
    lane(2, 1'b1, 20, 1'b1);
    lane(3, 1'b1, 30, 1'b1);
    #1;
    total++; if (bif.o_req_ready !== 4'b0100) begin bad++; $display("FAIL bp_first_ready got=%b exp=0100", bif.o_req_ready); end
    step;
    lane(2, 1'b0, 0, 1'b0);
    bif.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bif.o_req_ready !== 4'b0000) begin bad++; $display("FAIL bp_stall_ready[%0d] got=%b exp=0000", i, bif.o_req_ready); end
      step;
      total++; if (bif.o_valid !== 1'b1 || bif.o_id !== 2'd2 || bif.o_data !== 8'd20) begin bad++; $display("FAIL bp_hold[%0d] got=%0b/%0d/%0d exp=1/2/20", i, bif.o_valid, bif.o_id, bif.o_data); end
    end
    bif.i_ready = 1'b1;
    #1;
    total++; if (bif.o_req_ready !== 4'b1000) begin bad++; $display("FAIL bp_resume_ready got=%b exp=1000", bif.o_req_ready); end
    step;
    total++; if (bif.o_valid !== 1'b1 || bif.o_id !== 2'd3 || bif.o_data !== 8'd30) begin bad++; $display("FAIL bp_next got=%0b/%0d/%0d exp=1/3/30", bif.o_valid, bif.o_id, bif.o_data); end
    lane(3, 1'b0, 0, 1'b0);
    step;
    total++; if (bif.o_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", bif.o_valid); end
  endtask

  task automatic test_reset_mid;
    lane(1, 1'b1, 7, 1'b0);
    step;
    total++; if (bif.o_valid !== 1'b1 || bif.o_id !== 2'd1) begin bad++; $display("FAIL rm_beat got=%0b/%0d exp=1/1", bif.o_valid, bif.o_id); end
    lane(1, 1'b0, 0, 1'b0);
    bif.i_ready = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    total++; if (bif.o_valid !== 1'b0 || bif.o_data !== 8'h00) begin bad++; $display("FAIL rm_flush got=%0b/%0h exp=0/0", bif.o_valid, bif.o_data); end
    lane(2, 1'b1, 9, 1'b1);
    bif.i_ready = 1'b1;
    #1;
    total++; if (bif.o_req_ready !== 4'b0100) begin bad++; $display("FAIL rm_unlock_ready got=%b exp=0100", bif.o_req_ready); end
    step;
    total++; if (bif.o_id !== 2'd2 || bif.o_data !== 8'd9) begin bad++; $display("FAIL rm_unlock_beat got=%0d/%0d exp=2/9", bif.o_id, bif.o_data); end
    lane(2, 1'b0, 0, 1'b0);
    step;
  endtask

  task automatic test_clr_cnt;
    lane(0, 1'b1, -500, 1'b1);
    step;
    lane(0, 1'b0, 0, 1'b0);
    total++; if (bif.o_sat !== 1'b1 || bif.o_data !== 8'h80) begin bad++; $display("FAIL clr_beat got=%0b/%0h exp=1/80", bif.o_sat, bif.o_data); end
    clr = 1'b1;
    step;
    clr = 1'b0;
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL clr_priority got=%0d exp=0", cnt); end
    lane(0, 1'b1, 300, 1'b1);
    step;
    lane(0, 1'b0, 0, 1'b0);
    step;
    total++; if (cnt !== 16'd1) begin bad++; $display("FAIL clr_recount got=%0d exp=1", cnt); end
  endtask

  initial begin
    test_reset;
    test_single_lane;
    test_saturate;
    test_round_robin;
    test_lock;
    test_backpressure;
    test_reset_mid;
    test_clr_cnt;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bound_arbiter.md
Name: bound_arbiter

Overview:
Shares one saturating requantization stage (signed AB_BW accumulator+bias to signed D_BW) among NUM_REQ accumulator lanes. Uses round-robin arbitration with per-packet grant lock. Produces a registered, tagged, valid/ready output stream and counts saturation events for debug. Sits between the PE-array accumulator lanes and the int8 activation writeback.

Parameters:
NUM_REQ, 4, number of requesting accumulator lanes
AB_BW, 21, accumulator+bias input width (two's complement)
D_BW, 8, saturated output width (two's complement)
ID_BW, 2, requester tag width, equals clog2(NUM_REQ)
CNT_BW, 16, saturation event counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
i_req_valid  in  NUM_REQ  per-lane beat valid
o_req_ready  out  NUM_REQ  per-lane beat accepted (one-hot or zero)
i_req_data  in  NUM_REQ*AB_BW  lane k data in bits [k*AB_BW +: AB_BW]
i_req_last  in  NUM_REQ  per-lane last beat of packet
o_valid  out  1  output beat valid
i_ready  in  1  downstream ready
o_data  out  D_BW  signed saturated result
o_id  out  ID_BW  index of the source lane
o_last  out  1  copy of accepted beat's last
o_sat  out  1  this beat was clamped
o_sat_cnt  out  CNT_BW  running count of clamped beats accepted downstream
i_clr_cnt  in  1  synchronous clear of o_sat_cnt

Behaviour:
- Reset: o_valid=0, o_data=0, o_id=0, o_last=0, o_sat=0, o_sat_cnt=0, priority pointer=0, FSM=IDLE. Reset mid-packet drops the lock and discards the held output beat.
- Output stage accepts a beat when can_acc = ~o_valid | i_ready.
- FSM IDLE:
  - Grant the first lane with i_req_valid, searching from the pointer upward and wrapping modulo NUM_REQ.
  - Assert o_req_ready[g] = can_acc in the same cycle.
  - If the accepted beat has last=0, go to LOCKED with lock_id=g.
  - If the accepted beat has last=1, stay in IDLE and set pointer=g+1 (wrap).
  - If there is no valid lane or can_acc=0, no grant; the pointer is unchanged.
- FSM LOCKED:
  - Only lock_id may be granted: o_req_ready[lock_id] = can_acc.
  - Other lanes are blocked even if lock_id drops valid mid-packet.
  - On an accepted beat with last=1: go to IDLE, pointer=lock_id+1.
- Accepted beat: input x interpreted as signed AB_BW.
  - x > 127 (2^(D_BW-1)-1): o_data=127, o_sat=1.
  - x < -128: o_data=-128, o_sat=1.
  - Otherwise o_data=x[D_BW-1:0], o_sat=0.
  - Boundaries: exactly -128 and 127 are not saturated.
- Latency: 1 cycle from acceptance to o_valid.
  - o_data/o_id/o_last/o_sat are registered together.
  - They are held stable while o_valid & ~i_ready.
  - o_valid clears when i_ready is high and no new beat is accepted.
- Throughput: 1 beat/cycle under continuous i_ready, including back-to-back packets from different lanes.
- o_sat_cnt:
  - Increments on o_valid & i_ready & o_sat.
  - Holds at all-ones (no wrap).
  - i_clr_cnt has priority over a same-cycle increment; the result is 0.
- o_req_ready is never asserted for a lane whose i_req_valid is low. At most one bit is high.

Decomposition:
- Package bound_pkg: D_BW, AB_BW, SAT_MAX=127, SAT_MIN=-128, FSM state enum {IDLE, LOCKED}, saturate function (shared with the standalone bound stage).
- Sub-module bound_rr_arb: pointer-based round-robin search returning grant index and grant-valid. Lock and FSM stay in bound_arbiter.

Test Plan:
- Single lane 0, single-beat packets 16, 60, -128 with i_ready=1 -> o_data 16, 60, -128 one cycle later; o_sat=0; o_id=0; o_sat_cnt=0.
- Lane 1 data -1000 then lane 2 data 200 -> o_data -128 (o_sat=1) then 127 (o_sat=1); o_sat_cnt=2; exactly 127 and -129 give o_sat 0 and 1 respectively.
- All 4 lanes valid with single-beat packets, continuous -> grant order 0,1,2,3,0,... with one beat per cycle.
- Lane 0 sends a 3-beat packet while lane 1 is valid; lane 0 drops valid for 2 cycles mid-packet -> lane 1 is not granted until lane 0's last beat; o_id sequence 0,0,0,1.
- i_ready low for 3 cycles with lanes valid -> o_data/o_id stable, all o_req_ready=0, no beat lost or duplicated after i_ready returns.
- Reset asserted mid-packet with o_valid=1 -> next cycle o_valid=0 and the lock is released. i_clr_cnt coincident with a saturated handshake -> o_sat_cnt=0.
